i2c_reg_sequencer: RTL and testbench

- Generic I2C register-table write sequencer, successor to the fixed-address HDMI config block.
- Walks an external table of {sub_addr, data} words and writes each to a parametrised 7-bit device. Contains its own bit engine, clocked by iCLK with a tick enable; no derived clock.
- Adds bounded NACK retry, error reporting, software restart and interrupt-triggered re-init.
- Used for ADV7513 HDMI TX, audio codecs and similar configuration-only I2C slaves.

---
 rtl/i2c_reg_sequencer_if.sv | 23 ++
 rtl/i2c_reg_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_sequencer_if.sv
// Table-fetch and control/status bundle between the I2C register sequencer and its host.
// The sequencer takes the master modport; the table/host side takes the slave modport.
interface i2c_reg_sequencer_if #(
    parameter int IDX_W = 6
) ();
    logic             iSTART;
    logic [IDX_W-1:0] oTBL_IDX;
    logic [15:0]      iTBL_DATA;
    logic             oBUSY;
    logic             oDONE;
    logic             oERR;
    logic [IDX_W-1:0] oERR_IDX;

    modport master (
        input  iSTART, iTBL_DATA,
        output oTBL_IDX, oBUSY, oDONE, oERR, oERR_IDX
    );

    modport slave (
        output iSTART, iTBL_DATA,
        input  oTBL_IDX, oBUSY, oDONE, oERR, oERR_IDX
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Walks a {sub_addr, data} table and writes each entry to one I2C device.
// Has its own tick-paced bit engine, bounded NACK retry and restart on iSTART or iINT_N.
module i2c_reg_sequencer #(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         I2C_FREQ  = 20000,
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         TBL_SIZE  = 31,
    parameter int         IDX_W     = 6,
    parameter int         MAX_RETRY = 3,
    parameter int         GAP_TICKS = 4
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iINT_N,
    output logic I2C_SCLK,
    inout  wire  I2C_SDAT,
    i2c_reg_sequencer_if.master seqIf
);
    localparam int DIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int DW      = $clog2(DIV);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW      = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [3:0] {
        IDLE, LOAD, START, SHIFT, STOP, GAP, NEXT, DONE, FAIL
    } state_t;

    state_t           state, stateNext;
    logic [DW-1:0]    divCnt;
    logic             tick;
    logic             intMeta, intSync;
    logic             restart;
    logic             sdaIn;
    logic [1:0]       phase, phaseNext;
    logic [4:0]       bitCnt, bitCntNext;
    logic [3:0]       byteBit, byteBitNext;
    logic [23:0]      shReg, shRegNext;
    logic             sclReg, sclNext;
    logic             sdaLow, sdaLowNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic [RW-1:0]    retry, retryNext;
    logic             nack, nackNext;
    logic [GW-1:0]    gapCnt, gapCntNext;
    logic [IDX_W-1:0] errIdx, errIdxNext;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            divCnt  <= '0;
            intMeta <= 1'b1;
            intSync <= 1'b1;
        end else begin
            divCnt  <= tick ? '0 : divCnt + 1'b1;
            intMeta <= iINT_N;
            intSync <= intMeta;
        end
    end

    assign tick    = (divCnt == DW'(DIV - 1));
    assign sdaIn   = I2C_SDAT;
    assign restart = seqIf.iSTART || (tick && !intSync);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            phase   <= '0;
            bitCnt  <= '0;
            byteBit <= '0;
            shReg   <= '0;
            sclReg  <= 1'b1;
            sdaLow  <= 1'b0;
            idx     <= '0;
            retry   <= '0;
            nack    <= 1'b0;
            gapCnt  <= '0;
            errIdx  <= '0;
        end else begin
            state   <= stateNext;
            phase   <= phaseNext;
            bitCnt  <= bitCntNext;
            byteBit <= byteBitNext;
            shReg   <= shRegNext;
            sclReg  <= sclNext;
            sdaLow  <= sdaLowNext;
            idx     <= idxNext;
            retry   <= retryNext;
            nack    <= nackNext;
            gapCnt  <= gapCntNext;
            errIdx  <= errIdxNext;
        end
    end

    always_comb begin
        stateNext   = state;
        phaseNext   = phase;
        bitCntNext  = bitCnt;
        byteBitNext = byteBit;
        shRegNext   = shReg;
        sclNext     = sclReg;
        sdaLowNext  = sdaLow;
        idxNext     = idx;
        retryNext   = retry;
        nackNext    = nack;
        gapCntNext  = gapCnt;
        errIdxNext  = errIdx;
        unique case (state)
            IDLE: stateNext = LOAD;
            LOAD: begin
                shRegNext = {DEV_ADDR, 1'b0, seqIf.iTBL_DATA};
                nackNext  = 1'b0;
                phaseNext = '0;
                if (tick) stateNext = START;
            end
            START: if (tick) begin
                if (phase == 2'd0) begin
                    sdaLowNext = 1'b1;
                    phaseNext  = 2'd1;
                end else begin
                    sclNext     = 1'b0;
                    phaseNext   = 2'd0;
                    bitCntNext  = '0;
                    byteBitNext = '0;
                    stateNext   = SHIFT;
                end
            end
            // Bit index 8 of each 9-bit group is the slave's ACK slot.
            SHIFT: if (tick) begin
                unique case (phase)
                    2'd0: begin
                        sdaLowNext = (byteBit == 4'd8) ? 1'b0 : ~shReg[23];
                        phaseNext  = 2'd1;
                    end
                    2'd1: begin
                        sclNext   = 1'b1;
                        phaseNext = 2'd2;
                    end
                    2'd2: begin
                        if (byteBit == 4'd8 && sdaIn) nackNext = 1'b1;
                        phaseNext = 2'd3;
                    end
                    default: begin
                        sclNext    = 1'b0;
                        phaseNext  = 2'd0;
                        bitCntNext = bitCnt + 5'd1;
                        if (byteBit == 4'd8) begin
                            byteBitNext = '0;
                            if (nack || bitCnt == 5'd26) stateNext = STOP;
                        end else begin
                            byteBitNext = byteBit + 4'd1;
                            shRegNext   = {shReg[22:0], 1'b0};
                        end
                    end
                endcase
            end
            STOP: if (tick) begin
                if (phase == 2'd0) begin
                    sdaLowNext = 1'b1;
                    phaseNext  = 2'd1;
                end else if (phase == 2'd1) begin
                    sclNext   = 1'b1;
                    phaseNext = 2'd2;
                end else begin
                    sdaLowNext = 1'b0;
                    phaseNext  = 2'd0;
                    gapCntNext = '0;
                    stateNext  = GAP;
                end
            end
            GAP: if (tick) begin
                if (int'(gapCnt) + 1 >= GAP_TICKS) begin
                    if (!nack) begin
                        stateNext = (idx == IDX_W'(TBL_SIZE - 1)) ? DONE : NEXT;
                    end else if (int'(retry) < MAX_RETRY) begin
                        retryNext = retry + 1'b1;
                        stateNext = LOAD;
                    end else begin
                        errIdxNext = idx;
                        stateNext  = FAIL;
                    end
                end else begin
                    gapCntNext = gapCnt + 1'b1;
                end
            end
            NEXT: begin
                idxNext   = idx + 1'b1;
                retryNext = '0;
                stateNext = LOAD;
            end
            DONE, FAIL: if (restart) begin
                idxNext   = '0;
                retryNext = '0;
                stateNext = LOAD;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign I2C_SCLK       = sclReg;
    assign I2C_SDAT       = sdaLow ? 1'b0 : 1'bz;
    assign seqIf.oTBL_IDX = idx;
    assign seqIf.oBUSY    = (state inside {LOAD, START, SHIFT, STOP, GAP, NEXT});
    assign seqIf.oDONE    = (state == DONE);
    assign seqIf.oERR     = (state == FAIL);
    assign seqIf.oERR_IDX = errIdx;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: an I2C slave/bus monitor decodes each transaction
// and checks it against a queue of expected transactions filled by the stimulus.
module tb_i2c_reg_sequencer;
    typedef struct packed {
        logic [4:0] nbits;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [2:0] acks;
    } txn_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic intN = 1'b1;
    logic scl;
    wire  sda;
    logic slvLow = 1'b0;

    pullup (sda);
    assign sda = slvLow ? 1'b0 : 1'bz;

    i2c_reg_sequencer_if #(.IDX_W(3)) seqIf ();

    i2c_reg_sequencer #(
        .CLK_FREQ(4000000), .I2C_FREQ(100000), .DEV_ADDR(7'h39),
        .TBL_SIZE(4), .IDX_W(3), .MAX_RETRY(2), .GAP_TICKS(4)
    ) dut (
        .iCLK(clk), .iRST_N(rstN), .iINT_N(intN),
        .I2C_SCLK(scl), .I2C_SDAT(sda), .seqIf(seqIf)
    );

    always #5 clk = ~clk;

    logic [15:0] tbl [8];
    assign seqIf.iTBL_DATA = tbl[seqIf.oTBL_IDX];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   aborted = 0;
    int   monRises = 0;
    bit   monInTxn = 0;
    bit   nackAddr = 0;
    logic [7:0] nackSub = 8'hFF;
    int   nackLeft = 0;
    txn_t expQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] getByte(input logic [31:0] v, input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = v[k*9+i];
        return b;
    endfunction

    function automatic txn_t decode(input logic [31:0] v, input int nb);
        txn_t t;
        t.nbits = 5'(nb);
        t.b0 = (nb >= 8)  ? getByte(v, 0) : 8'h00;
        t.b1 = (nb >= 17) ? getByte(v, 1) : 8'h00;
        t.b2 = (nb >= 26) ? getByte(v, 2) : 8'h00;
        t.acks = {(nb >= 27) ? v[26] : 1'b0, (nb >= 18) ? v[17] : 1'b0, (nb >= 9) ? v[8] : 1'b0};
        return t;
    endfunction

    task automatic expEntry(input int e, input logic [2:0] acks);
        txn_t t;
        t.nbits = 5'd27;
        t.b0 = 8'h72;
        t.b1 = tbl[e][15:8];
        t.b2 = tbl[e][7:0];
        t.acks = acks;
        expQ.push_back(t);
    endtask

    task automatic expAddrNack();
        txn_t t;
        t.nbits = 5'd9;
        t.b0 = 8'h72;
        t.b1 = 8'h00;
        t.b2 = 8'h00;
        t.acks = 3'b001;
        expQ.push_back(t);
    endtask

    // Bus monitor plus ACK-ing slave; compares each STOP-terminated transaction.
    initial begin
        logic [31:0] bitsV = '0;
        int   tFirst = 0, tLast = 0, nb, k;
        logic pScl = 1'b1, pSda = 1'b1;
        bit   nackIt;
        txn_t got, want;
        forever begin
            @(negedge clk);
            if (scl && pScl && pSda && !sda) begin
                if (monInTxn) aborted++;
                monInTxn = 1;
                monRises = 0;
                bitsV = '0;
                slvLow = 1'b0;
            end else if (scl && pScl && !pSda && sda) begin
                if (monInTxn) begin
                    nb = monRises - 1;
                    got = decode(bitsV, nb);
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_txn: got %h expected none", got);
                    end else begin
                        want = expQ.pop_front();
                        check("txn", got, want);
                        check("txn_cycles", tLast - tFirst, nb * 40);
                    end
                end
                monInTxn = 0;
            end else if (monInTxn && scl && !pScl) begin
                if (monRises == 0) tFirst = cyc;
                tLast = cyc;
                if (monRises < 32) bitsV[monRises] = sda;
                monRises++;
            end else if (monInTxn && !scl && pScl) begin
                slvLow = 1'b0;
                if (monRises % 9 == 8 && monRises < 27) begin
                    k = monRises / 9;
                    nackIt = 0;
                    if (k == 0) begin
                        nackIt = nackAddr || (getByte(bitsV, 0) != 8'h72);
                    end else if (k == 2 && getByte(bitsV, 1) == nackSub && nackLeft > 0) begin
                        nackIt = 1;
                        nackLeft--;
                    end
                    slvLow = !nackIt;
                end
            end
            pScl = scl;
            pSda = sda;
        end
    end

    task automatic waitEnd(input string nm);
        int n = 0;
        while (!(seqIf.oDONE || seqIf.oERR) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(n < 20000), 32'd1);
    endtask

    task automatic pulseStart();
        seqIf.iSTART = 1'b1;
        @(negedge clk);
        seqIf.iSTART = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) tbl[i] = 16'hDEAD;
        tbl[0] = 16'h9803;
        tbl[1] = 16'h0100;
        tbl[2] = 16'h0218;
        tbl[3] = 16'h1470;
        seqIf.iSTART = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_idx", 32'(seqIf.oTBL_IDX), 32'd0);
        check("rst_busy", 32'(seqIf.oBUSY), 32'd0);
        check("rst_done", 32'(seqIf.oDONE), 32'd0);
        check("rst_err", 32'(seqIf.oERR), 32'd0);
        check("rst_erridx", 32'(seqIf.oERR_IDX), 32'd0);

        // Full sequence after reset, with an ignored iSTART mid-way
        for (int e = 0; e < 4; e++) expEntry(e, 3'b000);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        check("autostart_busy", 32'(seqIf.oBUSY), 32'd1);
        repeat (2000) @(negedge clk);
        check("mid_busy", 32'(seqIf.oBUSY), 32'd1);
        pulseStart();
        waitEnd("wait_done_a");
        check("a_done", 32'(seqIf.oDONE), 32'd1);
        check("a_busy", 32'(seqIf.oBUSY), 32'd0);
        check("a_err", 32'(seqIf.oERR), 32'd0);
        check("a_idx", 32'(seqIf.oTBL_IDX), 32'd3);
        repeat (1500) @(negedge clk);
        check("a_drained", 32'(expQ.size()), 32'd0);

        // Entry 2 data byte NACKed twice, third attempt succeeds
        nackSub = 8'h02;
        nackLeft = 2;
        expEntry(0, 3'b000);
        expEntry(1, 3'b000);
        expEntry(2, 3'b100);
        expEntry(2, 3'b100);
        expEntry(2, 3'b000);
        expEntry(3, 3'b000);
        pulseStart();
        repeat (2) @(negedge clk);
        check("b_done_clr", 32'(seqIf.oDONE), 32'd0);
        waitEnd("wait_done_b");
        check("b_done", 32'(seqIf.oDONE), 32'd1);
        check("b_err", 32'(seqIf.oERR), 32'd0);
        check("b_drained", 32'(expQ.size()), 32'd0);
        nackSub = 8'hFF;

        // Interrupt-triggered re-init: 3 ticks low gives exactly one re-run
        for (int e = 0; e < 4; e++) expEntry(e, 3'b000);
        intN = 1'b0;
        repeat (15) @(negedge clk);
        check("c_done_drop", 32'(seqIf.oDONE), 32'd0);
        repeat (15) @(negedge clk);
        intN = 1'b1;
        waitEnd("wait_done_c");
        check("c_done", 32'(seqIf.oDONE), 32'd1);
        repeat (1500) @(negedge clk);
        check("c_drained", 32'(expQ.size()), 32'd0);
        check("c_still_done", 32'(seqIf.oDONE), 32'd1);

        // Address always NACKed: 1 + MAX_RETRY attempts, then FAIL at index 0
        nackAddr = 1;
        for (int i = 0; i < 3; i++) expAddrNack();
        pulseStart();
        repeat (2) @(negedge clk);
        waitEnd("wait_end_d");
        check("d_err", 32'(seqIf.oERR), 32'd1);
        check("d_erridx", 32'(seqIf.oERR_IDX), 32'd0);
        check("d_busy", 32'(seqIf.oBUSY), 32'd0);
        check("d_done", 32'(seqIf.oDONE), 32'd0);
        check("d_drained", 32'(expQ.size()), 32'd0);
        nackAddr = 0;

        // Last entry data always NACKed: FAIL at index 3, restart from FAIL clears oERR
        nackSub = 8'h14;
        nackLeft = 100;
        for (int e = 0; e < 3; e++) expEntry(e, 3'b000);
        for (int i = 0; i < 3; i++) expEntry(3, 3'b100);
        pulseStart();
        repeat (2) @(negedge clk);
        check("e_err_clr", 32'(seqIf.oERR), 32'd0);
        waitEnd("wait_end_e");
        check("e_err", 32'(seqIf.oERR), 32'd1);
        check("e_erridx", 32'(seqIf.oERR_IDX), 32'd3);
        check("e_done", 32'(seqIf.oDONE), 32'd0);
        check("e_drained", 32'(expQ.size()), 32'd0);
        nackSub = 8'hFF;
        nackLeft = 0;

        // Reset during bit 12 of entry 1: bus released at once, restart from entry 0
        expEntry(0, 3'b000);
        pulseStart();
        n = 0;
        while (!(seqIf.oTBL_IDX == 3'd1 && monInTxn && monRises == 11 && scl == 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("f_reached_bit12", 32'(n < 20000), 32'd1);
        check("f_pre_sda", 32'(sda), 32'd0);
        rstN = 1'b0;
        #1;
        check("f_rst_scl", 32'(scl), 32'd1);
        check("f_rst_sda", 32'(sda), 32'd1);
        check("f_rst_idx", 32'(seqIf.oTBL_IDX), 32'd0);
        for (int e = 0; e < 4; e++) expEntry(e, 3'b000);
        repeat (5) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        waitEnd("wait_done_f");
        check("f_done", 32'(seqIf.oDONE), 32'd1);
        repeat (500) @(negedge clk);
        check("f_drained", 32'(expQ.size()), 32'd0);
        check("f_aborted", 32'(aborted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
